// File: rtl/alu_decode_stage.sv
// Registered MIPS decode stage feeding the ALU: one-beat output register plus a skid entry.
// Optional macro ALU_DEC_ITYPE_EN adds decoding of the I-type arithmetic/logic immediates.
module alu_decode_stage #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [31:0]  instr_i,
  input  logic [N-1:0] rs_data_i,
  input  logic [N-1:0] rt_data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [3:0]   operacion_o,
  output logic         invert_o,
  output logic         c_o,
  output logic         ill_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic signed [N-1:0] zext5(input logic [4:0] v);
    return N'(v);
  endfunction

`ifdef ALU_DEC_ITYPE_EN
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;

  function automatic logic signed [N-1:0] sext16(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return N'(s);
  endfunction

  function automatic logic signed [N-1:0] zext16(input logic [15:0] v);
    return N'(v);
  endfunction

  logic unused_fields;
  assign unused_fields = ^instr_i[25:16];
`else
  logic unused_fields;
  assign unused_fields = ^instr_i[25:11];
`endif

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic signed [N-1:0] dec_a_p0;
  logic signed [N-1:0] dec_b_p0;
  logic [3:0]          dec_op_p0;
  logic                dec_sub_p0;
  logic                dec_ill_p0;
  logic                use_rr;
  logic                use_sh;
  logic                use_imm_s;
  logic                use_imm_z;

  always_comb begin
    dec_a_p0   = '0;
    dec_b_p0   = '0;
    dec_op_p0  = OP_ADD;
    dec_sub_p0 = 1'b0;
    dec_ill_p0 = 1'b1;
    use_rr     = 1'b0;
    use_sh     = 1'b0;
    use_imm_s  = 1'b0;
    use_imm_z  = 1'b0;

    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin dec_op_p0 = OP_ADD; use_rr = 1'b1; end
          F_SUB, F_SUBU: begin dec_op_p0 = OP_ADD; dec_sub_p0 = 1'b1; use_rr = 1'b1; end
          F_AND:         begin dec_op_p0 = OP_AND; use_rr = 1'b1; end
          F_OR:          begin dec_op_p0 = OP_OR;  use_rr = 1'b1; end
          F_XOR:         begin dec_op_p0 = OP_XOR; use_rr = 1'b1; end
          F_NOR:         begin dec_op_p0 = OP_NOR; use_rr = 1'b1; end
          F_SLT, F_SLTU: begin dec_op_p0 = OP_SLT; dec_sub_p0 = 1'b1; use_rr = 1'b1; end
          F_SLL:         begin dec_op_p0 = OP_SLL; use_sh = 1'b1; end
          F_SRL:         begin dec_op_p0 = OP_SRL; use_sh = 1'b1; end
          F_SRA:         begin dec_op_p0 = OP_SRA; use_sh = 1'b1; end
          default: ;
        endcase
      end
`ifdef ALU_DEC_ITYPE_EN
      OPC_ADDI, OPC_ADDIU: begin dec_op_p0 = OP_ADD; use_imm_s = 1'b1; end
      OPC_SLTI, OPC_SLTIU: begin dec_op_p0 = OP_SLT; dec_sub_p0 = 1'b1; use_imm_s = 1'b1; end
      OPC_ANDI:            begin dec_op_p0 = OP_AND; use_imm_z = 1'b1; end
      OPC_ORI:             begin dec_op_p0 = OP_OR;  use_imm_z = 1'b1; end
      OPC_XORI:            begin dec_op_p0 = OP_XOR; use_imm_z = 1'b1; end
`endif
      default: ;
    endcase

    if (use_rr) begin
      dec_a_p0   = rs_data_i;
      dec_b_p0   = rt_data_i;
      dec_ill_p0 = 1'b0;
    end
    // Shifts take the value from rt and the amount from the shamt field.
    if (use_sh) begin
      dec_a_p0   = rt_data_i;
      dec_b_p0   = zext5(instr_i[10:6]);
      dec_ill_p0 = 1'b0;
    end
`ifdef ALU_DEC_ITYPE_EN
    if (use_imm_s || use_imm_z) begin
      dec_a_p0   = rs_data_i;
      dec_b_p0   = use_imm_s ? sext16(instr_i[15:0]) : zext16(instr_i[15:0]);
      dec_ill_p0 = 1'b0;
    end
`endif
  end

  // ---- skid control ----
  state_t state;
  state_t state_next;
  logic   ready_q;
  logic   vld_p1;
  logic   accept;
  logic   drain;
  logic   load_out;
  logic   load_skid;
  logic   move_skid;

  assign accept = valid_i & ready_q;
  assign drain  = vld_p1 & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= EMPTY;
      vld_p1  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      vld_p1  <= (state_next != EMPTY);
      ready_q <= (state_next != TWO);
    end
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // ready_o is low here, so only a drain can happen.
        if (drain) begin
          state_next = ONE;
          move_skid  = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // ---- stage p1: skid entry, holds the second beat while the output is stalled ----
  logic signed [N-1:0] skid_a_p1;
  logic signed [N-1:0] skid_b_p1;
  logic [3:0]          skid_op_p1;
  logic                skid_sub_p1;
  logic                skid_ill_p1;

  always_ff @(posedge clk_i) begin
    if (load_skid) begin
      skid_a_p1   <= dec_a_p0;
      skid_b_p1   <= dec_b_p0;
      skid_op_p1  <= dec_op_p0;
      skid_sub_p1 <= dec_sub_p0;
      skid_ill_p1 <= dec_ill_p0;
    end
  end

  // ---- stage p1: output register ----
  logic signed [N-1:0] a_p1;
  logic signed [N-1:0] b_p1;
  logic [3:0]          op_p1;
  logic                sub_p1;
  logic                ill_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_p1   <= '0;
      b_p1   <= '0;
      op_p1  <= OP_AND;
      sub_p1 <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (load_out) begin
      a_p1   <= dec_a_p0;
      b_p1   <= dec_b_p0;
      op_p1  <= dec_op_p0;
      sub_p1 <= dec_sub_p0;
      ill_p1 <= dec_ill_p0;
    end else if (move_skid) begin
      a_p1   <= skid_a_p1;
      b_p1   <= skid_b_p1;
      op_p1  <= skid_op_p1;
      sub_p1 <= skid_sub_p1;
      ill_p1 <= skid_ill_p1;
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = vld_p1;
  assign a_o         = a_p1;
  assign b_o         = b_p1;
  assign operacion_o = op_p1;
  assign invert_o    = sub_p1;
  assign c_o         = sub_p1;
  assign ill_o       = ill_p1;

endmodule
